axis_pattern_gen: RTL and testbench
===================================

Name: axis_pattern_gen

Overview:
Parametrised AXI-Stream test-pattern source feeding the S2MM DMA path. It produces framed bursts with programmable length, inter-frame gap, frame count and data pattern (count, LFSR, legacy marker, walking-one). It sits in the same slot as the fixed 32-bit block generator and is gated by the S2MM channel-running signal. It also reports status for software bring-up of the USB/DMA streaming chain.

Parameters:
DATA_W, 32, tdata width in bits; multiple of 8, range 8..256
LEN_W, 16, width of the beats-per-frame config and beat counter
GAP_W, 8, width of the idle-cycles-between-frames config
CNT_W, 16, width of the frame-count config and status counter

Ports:
aclk  in  1  clock, all logic rising-edge
aresetn  in  1  asynchronous active-low reset
s2mm_prmry_resetn  in  1  1 = S2MM channel running; 0 = silent/abort
cfg_mode  in  2  0 COUNT, 1 LFSR, 2 MARKER, 3 WALK1
cfg_words  in  LEN_W  beats per frame; 0 treated as 1
cfg_gap  in  GAP_W  idle cycles between frames (tvalid=0)
cfg_frames  in  CNT_W  frames to send; 0 = continuous
m_axis_tdata  out  DATA_W  pattern data
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tlast  out  1  last beat of frame
m_axis_tkeep  out  DATA_W/8  always all ones
busy  out  1  1 in SEND or GAP
done  out  1  1 in DONE (frame quota met)
frames_sent  out  CNT_W  frames completed since enable

Behaviour:
- Reset (aresetn=0, async): state IDLE, tvalid=0, tlast=0, tdata=0, beat=0, frames_sent=0, lfsr=32'hFFFF_FFFF, busy=0, done=0. tkeep is constant all-ones.
- s2mm_prmry_resetn=0 (sync): same values as reset, any state, mid-frame included; abort is immediate (tvalid drops without tlast); intentional, downstream is held in reset too.
- hs = tvalid & tready. While tvalid=1 and !hs: tdata, tlast and tvalid are held stable.
- IDLE -> SEND on the first cycle with en=1. At entry, latch cfg_mode, max(cfg_words,1), cfg_gap; beat=0; tvalid=1 next cycle with beat-0 data (1 cycle enable-to-valid latency).
- SEND: on hs with beat<N-1: beat+1, next data. tlast = (beat==N-1). On hs of the last beat: frames_sent+1; if cfg_frames!=0 and frames_sent+1==cfg_frames -> DONE; else if gap==0 -> re-latch cfg, tvalid stays 1 with new beat-0 data (back-to-back frames); else -> GAP with tvalid=0.
- GAP: down-counter from latched gap; exactly cfg_gap cycles with tvalid=0, then re-latch cfg and enter SEND as above.
- DONE: tvalid=0, done=1; exit only via en=0 or reset (returns to IDLE, frames_sent cleared).
- cfg_* changes mid-frame have no effect until the next frame start.
- Patterns (beat = beat index, zero-extended/truncated to DATA_W):
  COUNT: tdata = beat.
  LFSR: 32-bit Fibonacci, taps 32,22,2,1, shift left, feedback into bit 0; advances once per hs; tdata = lfsr replicated, truncated to DATA_W; not reseeded between frames, reseeded to all-ones only on reset or en=0.
  MARKER: all bytes 8'hAA except byte 0 = beat[7:0] (legacy format).
  WALK1: single 1 at bit position (beat mod DATA_W).
- frames_sent saturates at all-ones in continuous mode.

Decomposition:
- Package axis_pattern_pkg: mode enum (COUNT/LFSR/MARKER/WALK1), state enum (IDLE/SEND/GAP/DONE), LFSR seed and tap constants, MARKER byte 8'hAA.
- Sub-module axis_pattern_lfsr32: enable-advanced 32-bit LFSR with sync seed load; everything else stays in the top level.

Test Plan:
- DATA_W=32, mode MARKER, cfg_words=16, gap=0, frames=1, tready=1 -> 16 beats AAAAAA00..AAAAAA0F, tlast only on beat 15, then done=1, frames_sent=1.
- Mode COUNT, words=4, gap=3, frames=2, tready=1 -> beats 0,1,2,3 / exactly 3 cycles tvalid=0 / 0,1,2,3, then DONE.
- Random tready (50%) in mode LFSR, words=8 -> data/tlast stable whenever stalled; beat sequence FFFFFFFF, FFFFFFFE, ... matches the reference LFSR model; no skipped or duplicated value.
- s2mm_prmry_resetn low at beat 5 of 16 -> tvalid=0 next cycle, frames_sent=0; re-enable restarts at beat 0 with LFSR reseeded.
- DATA_W=64, mode WALK1, words=70, frames=0 -> bit position wraps 63->0 at beat 64; continuous back-to-back frames; cfg_words=0 yields 1-beat frames with tlast on every beat.
- aresetn asserted asynchronously mid-beat -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/axis_pattern_pkg.sv
// rtl/axis_pattern_pkg.sv - shared modes, states and constants for the AXI-Stream pattern generator
package axis_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT  = 2'd0,
      MODE_LFSR   = 2'd1,
      MODE_MARKER = 2'd2,
      MODE_WALK1  = 2'd3
   } mode_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0
   localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   localparam logic [7:0] MARKER_BYTE = 8'hAA;

endpackage

// File: rtl/axis_pattern_lfsr32.sv
// rtl/axis_pattern_lfsr32.sv - enable-advanced 32-bit Fibonacci LFSR with synchronous seed load
module axis_pattern_lfsr32
   import axis_pattern_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] value,
   output logic [31:0] next_value
);

   // next_value is exposed so the owner can present post-advance data in the same cycle
   assign next_value = {value[30:0], ^(value & LFSR_TAPS)};

   // seed load wins over advance so a channel stop always leaves a known state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= LFSR_SEED;
      end else if (load) begin
         value <= LFSR_SEED;
      end else if (advance) begin
         value <= next_value;
      end
   end

endmodule

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - framed AXI-Stream test-pattern source for the S2MM DMA path
module axis_pattern_gen
   import axis_pattern_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16,
   parameter int GAP_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                s2mm_prmry_resetn,
   input  logic [1:0]          cfg_mode,
   input  logic [LEN_W-1:0]    cfg_words,
   input  logic [GAP_W-1:0]    cfg_gap,
   input  logic [CNT_W-1:0]    cfg_frames,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic [DATA_W/8-1:0] m_axis_tkeep,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    frames_sent
);

   logic [1:0]        state;
   mode_e             mode_q;
   logic [LEN_W-1:0]  words_q;
   logic [LEN_W-1:0]  beat;
   logic [GAP_W-1:0]  gap_q;
   logic [GAP_W-1:0]  gap_cnt;

   logic              en;
   logic              hs;
   logic              last_beat;
   logic              quota_met;
   logic              start;
   logic [LEN_W-1:0]  words_eff;
   logic [LEN_W-1:0]  beat_inc;
   logic [CNT_W-1:0]  frames_inc;
   logic [31:0]       lfsr_value;
   logic [31:0]       lfsr_next;
   logic [31:0]       lfsr_src;
   logic [DATA_W-1:0] data_first;
   logic [DATA_W-1:0] data_step;

   // beat-indexed pattern; the LFSR word is supplied already advanced for this beat
   function automatic logic [DATA_W-1:0] pattern(input mode_e mode,
                                                 input logic [LEN_W-1:0] idx,
                                                 input logic [31:0] lfsr);
      logic [DATA_W-1:0] d;
      logic [31:0]       pos;
      pos = 32'(idx) % 32'(DATA_W);
      case (mode)
         MODE_COUNT:  d = DATA_W'(idx);
         MODE_LFSR:   d = DATA_W'({((DATA_W + 31) / 32){lfsr}});
         MODE_MARKER: begin
            d      = {(DATA_W/8){MARKER_BYTE}};
            d[7:0] = 8'(idx);
         end
         default:     d = DATA_W'(1) << pos;
      endcase
      return d;
   endfunction

   assign en         = s2mm_prmry_resetn;
   assign hs         = m_axis_tvalid & m_axis_tready;
   assign words_eff  = (cfg_words == '0) ? LEN_W'(1) : cfg_words;
   assign beat_inc   = beat + LEN_W'(1);
   assign last_beat  = (beat == words_q - LEN_W'(1));
   assign frames_inc = frames_sent + CNT_W'(1);
   assign quota_met  = (cfg_frames != '0) && (frames_inc == cfg_frames);

   // a handshake this cycle advances the LFSR, so data loaded now must use its next value
   assign lfsr_src   = hs ? lfsr_next : lfsr_value;
   assign data_first = pattern(mode_e'(cfg_mode), '0, lfsr_src);
   assign data_step  = pattern(mode_q, beat_inc, lfsr_src);

   assign busy         = (state == ST_SEND) || (state == ST_GAP);
   assign done         = (state == ST_DONE);
   assign m_axis_tkeep = '1;

   axis_pattern_lfsr32 u_lfsr (
      .clk        (aclk),
      .rst_n      (aresetn),
      .load       (!en),
      .advance    (hs),
      .value      (lfsr_value),
      .next_value (lfsr_next)
   );

   // frame start points: leaving IDLE, back-to-back after a last beat, or end of gap
   always_comb begin
      start = 1'b0;
      case (state)
         ST_IDLE: start = 1'b1;
         ST_SEND: start = hs && last_beat && !quota_met && (gap_q == '0);
         ST_GAP:  start = (gap_cnt <= GAP_W'(1));
         default: start = 1'b0;
      endcase
   end

   // frame sequencer and registered stream outputs; channel stop acts like reset
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= ST_IDLE;
         mode_q        <= MODE_COUNT;
         words_q       <= LEN_W'(1);
         gap_q         <= '0;
         gap_cnt       <= '0;
         beat          <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         frames_sent   <= '0;
      end else if (!en) begin
         state         <= ST_IDLE;
         mode_q        <= MODE_COUNT;
         words_q       <= LEN_W'(1);
         gap_q         <= '0;
         gap_cnt       <= '0;
         beat          <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         frames_sent   <= '0;
      end else begin
         if (hs && last_beat) begin
            frames_sent <= (&frames_sent) ? frames_sent : frames_inc;
         end
         if (start) begin
            state         <= ST_SEND;
            mode_q        <= mode_e'(cfg_mode);
            words_q       <= words_eff;
            gap_q         <= cfg_gap;
            beat          <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (words_eff == LEN_W'(1));
            m_axis_tdata  <= data_first;
         end else begin
            case (state)
               ST_SEND: begin
                  if (hs) begin
                     if (!last_beat) begin
                        beat         <= beat_inc;
                        m_axis_tdata <= data_step;
                        m_axis_tlast <= (beat_inc == words_q - LEN_W'(1));
                     end else begin
                        state         <= quota_met ? ST_DONE : ST_GAP;
                        gap_cnt       <= gap_q;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                     end
                  end
               end
               ST_GAP:  gap_cnt <= gap_cnt - GAP_W'(1);
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - randomized self-checking bench for axis_pattern_gen at 32 and 64 bits
module tb_axis_pattern_gen;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        en = 1'b0;
   logic        tready = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [15:0] cfg_words = 16'd1;
   logic [7:0]  cfg_gap = 8'd0;
   logic [15:0] cfg_frames = 16'd1;

   logic [31:0] d32;
   logic        v32, l32, b32, dn32;
   logic [3:0]  k32;
   logic [15:0] fs32;
   logic [63:0] d64;
   logic        v64, l64, b64, dn64;
   logic [7:0]  k64;
   logic [15:0] fs64;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axis_pattern_gen #(.DATA_W(32)) dut32 (
      .aclk(clk), .aresetn(aresetn), .s2mm_prmry_resetn(en),
      .cfg_mode(cfg_mode), .cfg_words(cfg_words), .cfg_gap(cfg_gap), .cfg_frames(cfg_frames),
      .m_axis_tdata(d32), .m_axis_tvalid(v32), .m_axis_tready(tready), .m_axis_tlast(l32),
      .m_axis_tkeep(k32), .busy(b32), .done(dn32), .frames_sent(fs32)
   );

   axis_pattern_gen #(.DATA_W(64)) dut64 (
      .aclk(clk), .aresetn(aresetn), .s2mm_prmry_resetn(en),
      .cfg_mode(cfg_mode), .cfg_words(cfg_words), .cfg_gap(cfg_gap), .cfg_frames(cfg_frames),
      .m_axis_tdata(d64), .m_axis_tvalid(v64), .m_axis_tready(tready), .m_axis_tlast(l64),
      .m_axis_tkeep(k64), .busy(b64), .done(dn64), .frames_sent(fs64)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   // expected word for beat k of a frame, built byte/bit-wise from the pattern rules
   function automatic logic [63:0] exp_data(input int w, input int mode, input int k, input logic [31:0] s);
      logic [63:0] d = '0;
      case (mode)
         0: d = 64'(k);
         1: for (int i = 0; i < w; i++) d[i] = s[i % 32];
         2: begin
            for (int b = 1; b < w / 8; b++) d[b*8 +: 8] = 8'hAA;
            d[7:0] = 8'(k);
         end
         default: d[k % w] = 1'b1;
      endcase
      if (w < 64) d = d & ((64'd1 << w) - 64'd1);
      return d;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_v32"}, v32, 0);   check({tag, "_v64"}, v64, 0);
      check({tag, "_l32"}, l32, 0);   check({tag, "_l64"}, l64, 0);
      check({tag, "_d32"}, d32, 0);   check({tag, "_d64"}, d64, 0);
      check({tag, "_busy"}, b32, 0);  check({tag, "_done"}, dn32, 0);
      check({tag, "_fs32"}, fs32, 0); check({tag, "_fs64"}, fs64, 0);
   endtask

   // run one enable window; abort_k>=0 drops the channel at that beat of the second frame
   task automatic stream(input int mode, input int words, input int gap, input int frames,
                         input int pct, input int max_beats, input int abort_k);
      int n = (words == 0) ? 1 : words;
      int k = 0;
      int f = 0;
      int hs_total = 0;
      int gap_left = 0;
      logic [31:0] lm = 32'hFFFF_FFFF;
      bit exp_v;
      bit rdy;
      bit fin = 0;
      @(negedge clk);
      cfg_mode   = mode[1:0];
      cfg_words  = 16'(words);
      cfg_gap    = 8'(gap);
      cfg_frames = 16'(frames);
      tready     = ($urandom_range(99) < pct);
      en         = 1'b1;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         @(negedge clk);
         exp_v = (gap_left == 0);
         check("tvalid32", v32, exp_v);  check("tvalid64", v64, exp_v);
         check("frames32", fs32, f);     check("frames64", fs64, f);
         check("busy32", b32, 1);        check("busy64", b64, 1);
         check("done32_run", dn32, 0);
         if (exp_v) begin
            check("tdata32", d32, exp_data(32, mode, k, lm));
            check("tdata64", d64, exp_data(64, mode, k, lm));
            check("tlast32", l32, k == n - 1);
            check("tlast64", l64, k == n - 1);
         end else begin
            gap_left--;
         end
         if (abort_k >= 0 && f == 1 && k == abort_k && exp_v) begin
            en  = 1'b0;
            fin = 1;
         end else begin
            rdy    = ($urandom_range(99) < pct);
            tready = rdy;
            if (exp_v && rdy) begin
               lm = lfsr_step(lm);
               hs_total++;
               if (k == n - 1) begin
                  k = 0;
                  f++;
                  if (frames != 0 && f == frames) fin = 1;
                  else gap_left = gap;
               end else begin
                  k++;
               end
               if (max_beats > 0 && hs_total >= max_beats) fin = 1;
            end
         end
      end
      check("stream_end", fin, 1);
      @(negedge clk);
      if (abort_k >= 0) begin
         check_idle("abort");
      end else if (frames != 0) begin
         check("done32", dn32, 1);       check("done64", dn64, 1);
         check("done_v32", v32, 0);      check("done_v64", v64, 0);
         check("done_busy32", b32, 0);   check("done_fs32", fs32, frames);
         check("done_fs64", fs64, frames);
         repeat (2) @(negedge clk);
         check("done_hold32", dn32, 1);  check("done_hold_v64", v64, 0);
      end else begin
         check("cont_busy32", b32, 1);   check("cont_fs32", fs32, f);
         check("cont_fs64", fs64, f);
      end
      en = 1'b0;
      @(negedge clk);
      check_idle("stop");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle("rst");
      check("keep32", k32, 4'hF);
      check("keep64", k64, 8'hFF);
      aresetn = 1'b1;
      @(negedge clk);
      check_idle("rst_rel");

      stream(2, 16, 0, 1, 100, 0, -1);
      stream(0, 4, 3, 2, 100, 0, -1);
      stream(1, 8, 1, 3, 50, 0, -1);
      stream(1, 16, 2, 0, 100, 0, 5);
      stream(1, 4, 0, 1, 100, 0, -1);
      stream(3, 70, 0, 0, 100, 140, -1);
      stream(0, 0, 0, 0, 70, 5, -1);
      for (int i = 0; i < 6; i++) begin
         stream(int'($urandom_range(3)), int'($urandom_range(12)), int'($urandom_range(4)),
                int'($urandom_range(3, 1)), int'($urandom_range(100, 30)), 0, -1);
      end

      @(negedge clk);
      cfg_mode   = 2'd0;
      cfg_words  = 16'd4;
      cfg_gap    = 8'd0;
      cfg_frames = 16'd0;
      tready     = 1'b1;
      en         = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      check("async_pre_v32", v32, 1);
      check("async_pre_busy", b64, 1);
      #1 aresetn = 1'b0;
      #1 check_idle("async");
      @(negedge clk);
      en      = 1'b0;
      aresetn = 1'b1;
      @(negedge clk);
      check_idle("post_async");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
